// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle between the multicycle control FSM and the datapath.
//               The master modport is the controller side: it observes the IR
//               opcode fields, the ALU zero flag and memory ready, and drives
//               every enable, mux select and status signal.
//               The slave modport is the datapath/memory side.
// Signals     : op[5:0], funct[5:0], zero, mem_ready      (datapath -> ctrl)
//               mem_req, iord, memwrite, irwrite, pcen,    (ctrl -> datapath)
//               regwrite, regdst, memtoreg, link, alusrca,
//               alusrcb[1:0], pcsrc[1:0], aluop[3:0],
//               illegal, state[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       link;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] aluop;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst,
           memtoreg, link, alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst,
           memtoreg, link, alusrca, alusrcb, pcsrc, aluop, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS control FSM. Steps a shared-memory datapath
//               through fetch/decode/execute/memory/writeback, one state per
//               clock, holding memory states until mem_ready. A memory access
//               that waits TIMEOUT_CYCLES cycles, or an unsupported opcode,
//               parks the FSM in FAULT with the sticky illegal flag set.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - multicycle_ctrl_if.master (opcode fields, zero,
//                       mem_ready in; enables, selects, illegal, state out)
// Parameters  : TIMEOUT_CYCLES - max wait cycles per memory access
//               CNT_W          - wait counter width, 2**CNT_W > TIMEOUT_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0, S_DECODE = 4'h1, S_MEMADR = 4'h2, S_MEMRD = 4'h3,
    S_MEMWB  = 4'h4, S_MEMWR  = 4'h5, S_EXEC   = 4'h6, S_ALUWB = 4'h7,
    S_BRANCH = 4'h8, S_IEXEC  = 4'h9, S_IWB    = 4'hA, S_JUMP  = 4'hB,
    S_JR     = 4'hC, S_JAL    = 4'hD, S_FAULT  = 4'hF
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  // Value the counter holds during the last allowed wait cycle.
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_illegal;

  logic       w_mem_state;
  logic       w_timeout;
  logic       w_mem_req, w_iord, w_memwrite, w_irwrite, w_pcwrite, w_branch;
  logic       w_regwrite, w_regdst, w_memtoreg, w_link, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [3:0] w_aluop;
  logic       w_ne;
  logic       w_pcen;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Only meaningful while waiting (mem_ready low); a ready on the last
  // count completes the access instead of faulting.
  assign w_timeout   = (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_state_n == S_FAULT) begin
        r_illegal <= 1'b1;
      end
      // Any state change (entry into a memory state included) or a ready
      // restarts the count; it only advances while a memory state is stalled.
      if (w_mem_state && !bus.mem_ready && (w_state_n == r_state)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_mem_req  = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_link     = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 4'b0000;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_state_n = S_DECODE;
        end else if (w_timeout) begin
          w_state_n = S_FAULT;
        end
      end
      S_DECODE: begin
        // ALUOut <= PC + (signext imm << 2), the speculative branch target.
        w_alusrcb = 2'b11;
        case (bus.op)
          c_OP_LW, c_OP_SW:    w_state_n = S_MEMADR;
          c_OP_RTYPE:          w_state_n = (bus.funct == c_FN_JR) ? S_JR : S_EXEC;
          c_OP_BEQ, c_OP_BNE:  w_state_n = S_BRANCH;
          c_OP_ADDI, c_OP_ORI: w_state_n = S_IEXEC;
          c_OP_J:              w_state_n = S_JUMP;
          c_OP_JAL:            w_state_n = S_JAL;
          default:             w_state_n = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_state_n = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready)  w_state_n = S_MEMWB;
        else if (w_timeout) w_state_n = S_FAULT;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (bus.mem_ready)  w_state_n = S_FETCH;
        else if (w_timeout) w_state_n = S_FAULT;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 4'b1111;
        w_state_n = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 4'b0001;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_state_n = S_FETCH;
      end
      S_IEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = (bus.op == c_OP_ORI) ? 4'b0011 : 4'b0000;
        w_state_n = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_state_n = S_FETCH;
      end
      S_JR: begin
        w_pcsrc   = 2'b11;
        w_pcwrite = 1'b1;
        w_state_n = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        w_pcsrc    = 2'b10;
        w_pcwrite  = 1'b1;
        w_regwrite = 1'b1;
        w_link     = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_FAULT: w_state_n = S_FAULT;
      default: w_state_n = S_FAULT;
    endcase
  end

  assign w_ne   = (bus.op == c_OP_BNE);
  assign w_pcen = w_pcwrite | (w_branch & (bus.zero ^ w_ne));

  // Architectural write strobes are masked while reset is asserted so that
  // a reset landing mid-instruction cannot commit a partial result.
  assign bus.mem_req  = w_mem_req;
  assign bus.iord     = w_iord;
  assign bus.memwrite = w_memwrite & ~reset;
  assign bus.irwrite  = w_irwrite  & ~reset;
  assign bus.pcen     = w_pcen     & ~reset;
  assign bus.regwrite = w_regwrite & ~reset;
  assign bus.regdst   = w_regdst;
  assign bus.memtoreg = w_memtoreg;
  assign bus.link     = w_link;
  assign bus.alusrca  = w_alusrca;
  assign bus.alusrcb  = w_alusrcb;
  assign bus.pcsrc    = w_pcsrc;
  assign bus.aluop    = w_aluop;
  assign bus.illegal  = r_illegal;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Bench for multicycle_ctrl (TIMEOUT_CYCLES=4). A reference model
//               tracks each instruction as a queue of remaining steps and
//               derives the expected outputs every cycle; directed sequences
//               pin the model with literal expectations, then random traffic
//               runs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam int CW = 3;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                 ST_BRANCH = 8, ST_IEXEC = 9, ST_IWB = 10, ST_JUMP = 11,
                 ST_JR = 12, ST_JAL = 13, ST_FAULT = 15;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, link, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop, state;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: current step, remaining steps of this instruction,
  // wait cycles of the current memory access, sticky illegal.
  int   m_state = ST_FETCH;
  int   m_path[$];
  int   m_wait  = 0;
  logic m_ill   = 1'b0;

  obs_t log_q[$];
  obs_t last;

  function automatic obs_t sample();
    obs_t o;
    o.mem_req = bus.mem_req;   o.iord = bus.iord;         o.memwrite = bus.memwrite;
    o.irwrite = bus.irwrite;   o.pcen = bus.pcen;         o.regwrite = bus.regwrite;
    o.regdst  = bus.regdst;    o.memtoreg = bus.memtoreg; o.link = bus.link;
    o.alusrca = bus.alusrca;   o.alusrcb = bus.alusrcb;   o.pcsrc = bus.pcsrc;
    o.aluop   = bus.aluop;     o.state = bus.state;       o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic obs_t expect_outs();
    obs_t e;
    e = '0;
    e.state   = 4'(m_state);
    e.illegal = m_ill;
    case (m_state)
      ST_FETCH:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.irwrite = bus.mem_ready; e.pcen = bus.mem_ready; end
      ST_DECODE: e.alusrcb = 2'b11;
      ST_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      ST_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      ST_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; end
      ST_MEMWB:  begin e.regwrite = 1; e.memtoreg = 1; end
      ST_EXEC:   begin e.alusrca = 1; e.aluop = 4'b1111; end
      ST_ALUWB:  begin e.regwrite = 1; e.regdst = 1; end
      ST_BRANCH: begin
        e.alusrca = 1; e.aluop = 4'b0001; e.pcsrc = 2'b01;
        // beq takes the branch on equal, bne on not-equal
        e.pcen = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
      end
      ST_IEXEC:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = (bus.op == OP_ORI) ? 4'b0011 : 4'b0000; end
      ST_IWB:    e.regwrite = 1;
      ST_JUMP:   begin e.pcsrc = 2'b10; e.pcen = 1; end
      ST_JR:     begin e.pcsrc = 2'b11; e.pcen = 1; end
      ST_JAL:    begin e.pcsrc = 2'b10; e.pcen = 1; e.regwrite = 1; e.link = 1; end
      default:   ;
    endcase
    if (reset) begin
      e.memwrite = 0; e.irwrite = 0; e.pcen = 0; e.regwrite = 0;
    end
    return e;
  endfunction

  task automatic next_step();
    if (m_path.size() > 0) m_state = m_path.pop_front();
    else                   m_state = ST_FETCH;
  endtask

  task automatic model_update();
    if (reset) begin
      m_state = ST_FETCH; m_path.delete(); m_wait = 0; m_ill = 1'b0;
    end else begin
      case (m_state)
        ST_FAULT: ;
        ST_FETCH, ST_MEMRD, ST_MEMWR: begin
          if (bus.mem_ready) begin
            m_wait = 0;
            if (m_state == ST_FETCH) m_state = ST_DECODE;
            else                     next_step();
          end else begin
            m_wait++;
            if (m_wait >= TO) begin
              m_state = ST_FAULT; m_ill = 1'b1; m_wait = 0; m_path.delete();
            end
          end
        end
        ST_DECODE: begin
          m_path.delete();
          case (bus.op)
            OP_LW:          m_path = '{ST_MEMADR, ST_MEMRD, ST_MEMWB};
            OP_SW:          m_path = '{ST_MEMADR, ST_MEMWR};
            OP_R:           if (bus.funct == 6'b001000) m_path = '{ST_JR};
                            else                        m_path = '{ST_EXEC, ST_ALUWB};
            OP_BEQ, OP_BNE: m_path = '{ST_BRANCH};
            OP_ADDI, OP_ORI: m_path = '{ST_IEXEC, ST_IWB};
            OP_J:           m_path = '{ST_JUMP};
            OP_JAL:         m_path = '{ST_JAL};
            default:        ;
          endcase
          if (m_path.size() == 0) begin
            m_state = ST_FAULT; m_ill = 1'b1;
          end else begin
            next_step();
          end
        end
        default: next_step();
      endcase
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    e = expect_outs();
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h (state act %0d req %0d)",
               $time, a, e, a.state, e.state);
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // One clock: apply inputs, observe this cycle's outputs, then advance.
  task automatic step(input logic [5:0] op_i, input logic [5:0] fn_i,
                      input logic z_i, input logic rdy_i, input logic rst_i);
    bus.op = op_i; bus.funct = fn_i; bus.zero = z_i; bus.mem_ready = rdy_i; reset = rst_i;
    @(negedge clk); #1;
    last = sample();
    log_q.push_back(last);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op_i, input logic [5:0] fn_i,
                           input logic z_i, output int cyc);
    log_q.delete();
    cyc = 0;
    do begin
      step(op_i, fn_i, z_i, 1'b1, 1'b0);
      cyc++;
    end while (m_state != ST_FETCH && m_state != ST_FAULT && cyc < 12);
  endtask

  logic [5:0] t_op [10] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_R, OP_JAL};
  logic [5:0] t_fn [10] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
  int         t_cyc[10] = '{4, 5, 4, 3, 3, 4, 4, 3, 3, 3};
  int         exp_lw[5] = '{0, 1, 2, 3, 4};
  logic [5:0] r_ops[10] = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_JAL};
  logic [5:0] r_fns[5]  = '{6'h20, 6'h22, 6'h08, 6'h25, 6'h2A};

  initial begin
    int cyc;
    int cnt_a;
    int cnt_b;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    logic       rst_r;

    reset = 1'b1; bus.op = OP_LW; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    step(OP_LW, 6'h00, 1'b0, 1'b1, 1'b1);

    // Reset state
    step(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_state",   int'(last.state), 0);
    chk("reset_mem_req", int'(last.mem_req), 1);
    chk("reset_alusrcb", int'(last.alusrcb), 1);
    chk("reset_irwrite", int'(last.irwrite), 0);
    chk("reset_illegal", int'(last.illegal), 0);

    // lw with immediate ready: 0,1,2,3,4 then back in FETCH
    run_instr(OP_LW, 6'h00, 1'b0, cyc);
    chk("lw_cycles", cyc, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lw_state_%0d", i),    int'(log_q[i].state), exp_lw[i]);
      chk($sformatf("lw_regwrite_%0d", i), int'(log_q[i].regwrite), (i == 4) ? 1 : 0);
      chk($sformatf("lw_memtoreg_%0d", i), int'(log_q[i].memtoreg), (i == 4) ? 1 : 0);
    end
    chk("lw_back_fetch", int'(bus.state), 0);

    // Cycle counts for every instruction class
    for (int i = 0; i < 10; i++) begin
      run_instr(t_op[i], t_fn[i], 1'b0, cyc);
      chk($sformatf("cycles_op%02h_fn%02h", t_op[i], t_fn[i]), cyc, t_cyc[i]);
      chk("back_to_fetch", int'(bus.state), 0);
    end

    // Branch decisions
    run_instr(OP_BEQ, 6'h00, 1'b1, cyc);
    chk("beq_z1_state", int'(log_q[2].state), 8);
    chk("beq_z1_pcen",  int'(log_q[2].pcen), 1);
    run_instr(OP_BNE, 6'h00, 1'b1, cyc);
    chk("bne_z1_pcen",  int'(log_q[2].pcen), 0);
    run_instr(OP_BNE, 6'h00, 1'b0, cyc);
    chk("bne_z0_pcen",  int'(log_q[2].pcen), 1);

    // jr and R-type add
    run_instr(OP_R, 6'h08, 1'b0, cyc);
    chk("jr_state", int'(log_q[2].state), 12);
    chk("jr_pcsrc", int'(log_q[2].pcsrc), 3);
    chk("jr_pcen",  int'(log_q[2].pcen), 1);
    run_instr(OP_R, 6'h20, 1'b0, cyc);
    chk("add_exec_state",  int'(log_q[2].state), 6);
    chk("add_exec_aluop",  int'(log_q[2].aluop), 15);
    chk("add_aluwb_state", int'(log_q[3].state), 7);
    chk("add_aluwb_regdst", int'(log_q[3].regdst), 1);

    // FETCH stalled 3 cycles, ready on the 4th (also the last allowed count)
    log_q.delete();
    for (int i = 0; i < 4; i++) step(OP_J, 6'h00, 1'b0, (i == 3), 1'b0);
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      cnt_a += int'(log_q[i].mem_req);
      cnt_b += int'(log_q[i].irwrite);
    end
    chk("fetch_wait_mem_req_cycles", cnt_a, 4);
    chk("fetch_wait_irwrite_pulses", cnt_b, 1);
    chk("fetch_wait_irwrite_4th",    int'(log_q[3].irwrite), 1);
    chk("fetch_wait_pcen_4th",       int'(log_q[3].pcen), 1);
    chk("fetch_wait_to_decode",      int'(bus.state), 1);
    step(OP_J, 6'h00, 1'b0, 1'b1, 1'b0);
    step(OP_J, 6'h00, 1'b0, 1'b1, 1'b0);

    // Illegal opcode -> FAULT, held, cleared by reset
    run_instr(OP_BAD, 6'h00, 1'b0, cyc);
    chk("bad_op_cycles", cyc, 2);
    log_q.delete();
    for (int i = 0; i < 10; i++) step(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b0);
    cnt_a = 0;
    foreach (log_q[i]) if (log_q[i].state == 4'hF && log_q[i].illegal && !log_q[i].mem_req) cnt_a++;
    chk("fault_held_10", cnt_a, 10);
    step(OP_LW, 6'h00, 1'b0, 1'b0, 1'b1);
    step(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("fault_reset_state",   int'(last.state), 0);
    chk("fault_reset_illegal", int'(last.illegal), 0);
    step(OP_SW, 6'h00, 1'b0, 1'b1, 1'b0);

    // sw with memory never ready: 4 wait cycles in MEMWR then FAULT
    step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
    step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
    log_q.delete();
    for (int i = 0; i < 4; i++) step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      if (log_q[i].state == 4'h5 && log_q[i].memwrite && log_q[i].mem_req) cnt_a++;
    end
    chk("sw_wait_cycles", cnt_a, 4);
    step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("sw_timeout_state",    int'(last.state), 15);
    chk("sw_timeout_illegal",  int'(last.illegal), 1);
    chk("sw_timeout_mem_req",  int'(last.mem_req), 0);
    chk("sw_timeout_memwrite", int'(last.memwrite), 0);
    step(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    cur_op = OP_LW; cur_fn = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      if (m_state == ST_FETCH) begin
        if ($urandom_range(0, 19) == 0) cur_op = 6'($urandom_range(0, 63));
        else                            cur_op = r_ops[$urandom_range(0, 9)];
        cur_fn = r_fns[$urandom_range(0, 4)];
      end
      if (m_state == ST_FAULT) rst_r = ($urandom_range(0, 3) == 0);
      else                     rst_r = ($urandom_range(0, 299) == 0);
      log_q.delete();
      step(cur_op, cur_fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), rst_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
